frame_blitter: RTL and testbench

- Parametrised full-frame / sprite blitter that feeds the VGA adapter.
- On a start pulse it latches a frame index and a screen origin, then scans a WIDTH x HEIGHT region row-major.
- It issues one ROM address per cycle, selects the chosen frame's colour from a packed multi-frame ROM bus, and emits aligned oX/oY/oColour/oPlot.
- A done pulse returns control to the game FSM.

---
 rtl/frame_blitter.sv | 177 +++++++++++++++++
 tb/tb_frame_blitter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/frame_blitter.sv
// Row-major region blitter: scans WIDTH x HEIGHT ROM addresses and emits aligned VGA plot strobes.
// Optional macro TRANSPARENCY_EN suppresses the plot strobe for pixels equal to TRANSPARENT_KEY.
module frame_blitter #(
    parameter int WIDTH           = 160,
    parameter int HEIGHT          = 120,
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int COLOR_W         = 3,
    parameter int NUM_FRAMES      = 7,
    parameter int SEL_W           = 3,
    parameter int ADDR_W          = 15,
    parameter int ROM_LAT         = 1,
    parameter int TRANSPARENT_KEY = 0
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic                          iStart,
    input  logic [SEL_W-1:0]              iFrameSel,
    input  logic [X_W-1:0]                iOriginX,
    input  logic [Y_W-1:0]                iOriginY,
    output logic [ADDR_W-1:0]             oRomAddr,
    input  logic [NUM_FRAMES*COLOR_W-1:0] iRomColour,
    output logic [X_W-1:0]                oX,
    output logic [Y_W-1:0]                oY,
    output logic [COLOR_W-1:0]            oColour,
    output logic                          oPlot,
    output logic                          oBusy,
    output logic                          oDone
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DW = $clog2(ROM_LAT + 2);
    localparam logic [CW-1:0]      COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0]      ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [DW-1:0]      DRN_LAST = DW'(ROM_LAT);
    localparam logic [COLOR_W-1:0] KEY      = COLOR_W'(TRANSPARENT_KEY);
`ifdef TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t               state_q;
    logic [SEL_W-1:0]     sel_q;
    logic [X_W-1:0]       orgx_q;
    logic [Y_W-1:0]       orgy_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DW-1:0]        drn_q;
    logic [ROM_LAT-1:0]   vld_q;
    logic [CW-1:0]        colp_q [ROM_LAT];
    logic [RW-1:0]        rowp_q [ROM_LAT];
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOR_W-1:0]   colour_q;
    logic                 plot_q;
    logic                 busy_q;
    logic                 done_q;

    logic [X_W-1:0]       x_d;
    logic [Y_W-1:0]       y_d;
    logic [COLOR_W-1:0]   colour_d;
    logic                 plot_d;
    logic                 vld_out;

    assign vld_out = vld_q[ROM_LAT-1];

    // Frame select: out-of-range indices fall through to colour 0.
    always_comb begin
        colour_d = '0;
        for (int k = 0; k < NUM_FRAMES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                colour_d = iRomColour[k*COLOR_W +: COLOR_W];
            end
        end
        x_d    = orgx_q + X_W'(colp_q[ROM_LAT-1]);
        y_d    = orgy_q + Y_W'(rowp_q[ROM_LAT-1]);
        plot_d = vld_out && !(TRANSP && (colour_d == KEY));
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            orgx_q   <= '0;
            orgy_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            drn_q    <= '0;
            vld_q    <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                colp_q[i] <= '0;
                rowp_q[i] <= '0;
            end
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Delay line keeps (col,row,valid) aligned with the ROM read data.
            vld_q[0]  <= (state_q == SCAN);
            colp_q[0] <= col_q;
            rowp_q[0] <= row_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                colp_q[i] <= colp_q[i-1];
                rowp_q[i] <= rowp_q[i-1];
            end

            plot_q <= plot_d;
            if (vld_out) begin
                x_q      <= x_d;
                y_q      <= y_d;
                colour_q <= colour_d;
            end

            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        sel_q   <= iFrameSel;
                        orgx_q  <= iOriginX;
                        orgy_q  <= iOriginY;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (col_q == COL_LAST && row_q == ROW_LAST) begin
                        drn_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                // ROM_LAT cycles of read latency plus the output register.
                DRAIN: begin
                    if (drn_q == DRN_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drn_q <= drn_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oRomAddr = addr_q;
    assign oX       = x_q;
    assign oY       = y_q;
    assign oColour  = colour_q;
    assign oPlot    = plot_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_frame_blitter.sv
// Bench for frame_blitter on a 4x3 region with a 2-cycle ROM; honours TRANSPARENCY_EN when defined.
module tb_frame_blitter;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
    localparam int LAT = 2;
    localparam int FIRST_K = LAT + 2;
    localparam int DONE_K = FIRST_K + N;
    localparam int RUN_K = DONE_K + 4;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iStart = 1'b0;
    logic [2:0]  iFrameSel = '0;
    logic [7:0]  iOriginX = '0;
    logic [6:0]  iOriginY = '0;
    logic [14:0] oRomAddr;
    logic [20:0] iRomColour;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [2:0]  oColour;
    logic        oPlot, oBusy, oDone;

    int checks = 0;
    int errors = 0;

    frame_blitter #(
        .WIDTH(W), .HEIGHT(H), .X_W(8), .Y_W(7), .COLOR_W(3), .NUM_FRAMES(7),
        .SEL_W(3), .ADDR_W(15), .ROM_LAT(LAT), .TRANSPARENT_KEY(0)
    ) dut (
        .iClock(clk), .iReset(iReset), .iStart(iStart), .iFrameSel(iFrameSel),
        .iOriginX(iOriginX), .iOriginY(iOriginY), .oRomAddr(oRomAddr),
        .iRomColour(iRomColour), .oX(oX), .oY(oY), .oColour(oColour),
        .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 clk = ~clk;

    // Frame ROMs: frame k at address a holds (a + 5k + 6) mod 8, so frame 2 returns a mod 8.
    function automatic int rom_c(int s, int a);
        return (a + 5 * s + 6) & 7;
    endfunction

    logic [14:0] a1 = '0;
    logic [14:0] a2 = '0;
    always @(posedge clk) begin
        a1 <= oRomAddr;
        a2 <= a1;
    end
    always_comb begin
        iRomColour = '0;
        for (int k = 0; k < 7; k++) iRomColour[k*3 +: 3] = 3'(rom_c(k, int'(a2)));
    end

    function automatic int model_c(int s, int a);
        return (s < 7) ? rom_c(s, a) : 0;
    endfunction

    function automatic bit visible(int s, int a);
`ifdef TRANSPARENCY_EN
        return model_c(s, a) != 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int model_count(int s);
        int n = 0;
        for (int a = 0; a < N; a++) if (visible(s, a)) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start a blit and check every output for RUN_K cycles against the pixel model.
    task automatic run_blit(input int sel, input int ox, input int oy, input int mid_k,
                            output int np, output int lx, output int ly);
        int a;
        bit ep;
        np = 0; lx = -1; ly = -1;
        @(negedge clk);
        iStart = 1'b1; iFrameSel = 3'(sel); iOriginX = 8'(ox); iOriginY = 7'(oy);
        for (int k = 1; k <= RUN_K; k++) begin
            @(negedge clk);
            a  = k - FIRST_K;
            ep = (a >= 0) && (a < N) && visible(sel, a);
            chk("plot", int'(oPlot), int'(ep));
            if (ep && oPlot) begin
                chk("x", int'(oX), (ox + a % W) % 256);
                chk("y", int'(oY), (oy + a / W) % 128);
                chk("colour", int'(oColour), model_c(sel, a));
            end
            if (oPlot) begin
                np++; lx = int'(oX); ly = int'(oY);
            end
            chk("done", int'(oDone), int'(k == DONE_K));
            chk("busy", int'(oBusy), int'(k <= DONE_K));
            if (k <= DONE_K) chk("addr", int'(oRomAddr), (k <= N) ? k - 1 : N - 1);
            iStart    = (mid_k != 0) && (k == mid_k || k == DONE_K);
            iFrameSel = 3'($urandom);
            iOriginX  = 8'($urandom);
            iOriginY  = 7'($urandom);
        end
        iStart = 1'b0;
    endtask

    typedef struct {
        int sel; int ox; int oy; int mid_k;
        int nplots; int lx; int ly;
    } vec_t;

`ifdef TRANSPARENCY_EN
    localparam int NP2 = 10;
    localparam int NP7 = 0;
`else
    localparam int NP2 = 12;
    localparam int NP7 = 12;
`endif

    initial begin
        vec_t tbl[4];
        int np, lx, ly, s, ox, oy, mk;

        tbl[0] = '{sel: 2, ox: 0,   oy: 0,   mid_k: 0, nplots: NP2, lx: 3,  ly: 2};
        tbl[1] = '{sel: 2, ox: 254, oy: 126, mid_k: 0, nplots: NP2, lx: 1,  ly: 0};
        tbl[2] = '{sel: 2, ox: 0,   oy: 0,   mid_k: 6, nplots: NP2, lx: 3,  ly: 2};
        tbl[3] = '{sel: 7, ox: 10,  oy: 20,  mid_k: 0, nplots: NP7, lx: 13, ly: 22};

        repeat (2) @(negedge clk);
        chk("rst_plot", int'(oPlot), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_done", int'(oDone), 0);
        chk("rst_addr", int'(oRomAddr), 0);
        chk("rst_x", int'(oX), 0);
        chk("rst_y", int'(oY), 0);
        chk("rst_colour", int'(oColour), 0);
        iReset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(oBusy), 0);

        for (int i = 0; i < 4; i++) begin
            run_blit(tbl[i].sel, tbl[i].ox, tbl[i].oy, tbl[i].mid_k, np, lx, ly);
            chk($sformatf("tbl%0d_nplots", i), np, tbl[i].nplots);
            if (tbl[i].nplots > 0) begin
                chk($sformatf("tbl%0d_lastx", i), lx, tbl[i].lx);
                chk($sformatf("tbl%0d_lasty", i), ly, tbl[i].ly);
            end
        end

        // Asynchronous reset on the 5th plot cycle, then a clean blit.
        @(negedge clk);
        iStart = 1'b1; iFrameSel = 3'd2; iOriginX = '0; iOriginY = '0;
        @(negedge clk);
        iStart = 1'b0;
        repeat (FIRST_K + 4 - 1) @(negedge clk);
        chk("abort_pre_plot", int'(oPlot), 1);
        #2 iReset = 1'b1;
        #1;
        chk("abort_plot", int'(oPlot), 0);
        chk("abort_busy", int'(oBusy), 0);
        chk("abort_done", int'(oDone), 0);
        @(negedge clk);
        iReset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", int'(oPlot | oDone | oBusy), 0);
        end
        run_blit(2, 0, 0, 0, np, lx, ly);
        chk("post_rst_nplots", np, NP2);
        chk("post_rst_lastx", lx, 3);
        chk("post_rst_lasty", ly, 2);

        for (int r = 0; r < 8; r++) begin
            s  = $urandom_range(0, 7);
            ox = $urandom_range(0, 255);
            oy = $urandom_range(0, 127);
            mk = ($urandom_range(0, 1) != 0) ? $urandom_range(2, DONE_K - 1) : 0;
            run_blit(s, ox, oy, mk, np, lx, ly);
            chk($sformatf("rand%0d_nplots", r), np, model_count(s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
